// File: rtl/dsp_seq_pkg.sv
// Shared constants, FSM states and pipeline tag type for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

    localparam logic [7:0] OPMODE_FIRST = 8'h01;
    localparam logic [7:0] OPMODE_ACC   = 8'h09;
    localparam logic [7:0] OPMODE_IDLE  = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESULT
    } state_t;

    typedef struct packed {
        logic live;
        logic first;
        logic last;
    } tag_t;

    localparam tag_t TAG_NONE = '{live: 1'b0, first: 1'b0, last: 1'b0};

    // The first product of a job must ignore whatever P still holds from before.
    function automatic logic [7:0] tag_opmode(input tag_t t);
        logic [7:0] mode;
        mode = OPMODE_IDLE;
        if (t.live) begin
            mode = t.first ? OPMODE_FIRST : OPMODE_ACC;
        end
        return mode;
    endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Tag delay line that shadows the slice's A/B/M pipeline; position 0 is the incoming tag.
module dsp_tag_pipe
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int OPM_TAP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t p_tag,
    output tag_t opm_tag
);

    generate
        if (DEPTH == 0) begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign p_tag          = tag_in;
            assign opm_tag        = tag_in;
        end else begin : g_reg
            // sr[k] holds the tag pushed k+1 cycles ago
            tag_t sr [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        sr[k] <= TAG_NONE;
                    end
                end else begin
                    sr[0] <= tag_in;
                    for (int k = 1; k < DEPTH; k++) begin
                        sr[k] <= sr[k-1];
                    end
                end
            end

            assign p_tag = sr[DEPTH-1];

            if (OPM_TAP == 0) begin : g_opm_comb
                assign opm_tag = tag_in;
            end else begin : g_opm_reg
                assign opm_tag = sr[OPM_TAP-1];
            end
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Job-level controller running one DSP48A1 slice as a dot-product MAC engine.
// Each accepted pair carries a tag down a delay line so OPMODE and CEP meet the product.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int PIPE_IN   = 1,
    parameter int MREG      = 1,
    parameter int OPMODEREG = 1,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [17:0]      op_a,
    input  logic [17:0]      op_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_ceopmode,
    output logic             dsp_cep,
    output logic [7:0]       dsp_opmode,
    input  logic [47:0]      dsp_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data
);

    localparam int D       = PIPE_IN + MREG;
    localparam int OPM_TAP = D - OPMODEREG;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             ce_on;
    logic             cap_pending;
    logic             op_fire;
    tag_t             tag_in;
    tag_t             p_tag;
    tag_t             opm_tag;
    logic             unused_tag_bits;

    assign op_fire = op_valid && op_ready;

    // Cycles without an accepted pair push a dead tag so bubbles stay aligned.
    always_comb begin
        tag_in = TAG_NONE;
        if (op_fire) begin
            tag_in.live  = 1'b1;
            tag_in.first = (cnt == len_q);
            tag_in.last  = (cnt == LEN_W'(1));
        end
    end

    dsp_tag_pipe #(
        .DEPTH   (D),
        .OPM_TAP (OPM_TAP)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .p_tag   (p_tag),
        .opm_tag (opm_tag)
    );

    assign dsp_a           = op_a;
    assign dsp_b           = op_b;
    assign dsp_cea         = ce_on;
    assign dsp_ceb         = ce_on;
    assign dsp_cem         = ce_on;
    assign dsp_ceopmode    = ce_on;
    assign dsp_cep         = p_tag.live;
    assign dsp_opmode      = tag_opmode(opm_tag);
    assign unused_tag_bits = p_tag.first ^ opm_tag.last;

    // cap_pending marks the cycle after the last product entered P, when P is final.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            op_ready    <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            cnt         <= '0;
            len_q       <= '0;
            cap_pending <= 1'b0;
            ce_on       <= 1'b0;
        end else begin
            ce_on       <= 1'b1;
            cap_pending <= p_tag.live && p_tag.last;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        cnt       <= cmd_len;
                        len_q     <= cmd_len;
                        if (cmd_len == '0) begin
                            res_data  <= '0;
                            res_valid <= 1'b1;
                            state     <= RESULT;
                        end else begin
                            op_ready <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (op_fire) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            op_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cap_pending) begin
                        res_data  <= dsp_p;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
